// File: rtl/match_result_drain_pkg.sv
// Shared types for the match-result drain: record layout, FSM encoding and
// the lowest-set-bit encoder used by the scanner.
package match_result_drain_pkg;

    localparam int unsigned WEIGHT_NUM_DEF = 23331;
    localparam int unsigned CHUNK_DEF      = 16;
    localparam int unsigned FIFO_DEPTH_DEF = 8;
    localparam int unsigned IDW            = 16;
    localparam int unsigned SIDW           = 8;

    // Widest scan window the encoder handles; CHUNK must not exceed it.
    localparam int unsigned CHUNK_MAX = 64;
    localparam int unsigned LSB_W     = $clog2(CHUNK_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EOS  = 2'd2
    } drain_state_e;

    typedef struct packed {
        logic            eos;
        logic [SIDW-1:0] sid;
        logic [IDW-1:0]  wid;
    } drain_rec_t;

    localparam int unsigned REC_W = $bits(drain_rec_t);

    // Index of the lowest set bit; returns 0 for an all-zero input.
    function automatic logic [LSB_W-1:0] lowest_set_bit(input logic [CHUNK_MAX-1:0] v);
        logic [LSB_W-1:0] idx;
        idx = '0;
        for (int i = int'(CHUNK_MAX) - 1; i >= 0; i--) begin
            if (v[LSB_W'(i)]) begin
                idx = LSB_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/match_result_drain_if.sv
// Capture/stream/status bundle between the controller, the drain and the
// record consumer.
interface match_result_drain_if
    import match_result_drain_pkg::*;
#(
    parameter int unsigned WEIGHT_NUM = WEIGHT_NUM_DEF
) ();

    logic                  res_valid;
    logic [WEIGHT_NUM-1:0] res_vec;
    logic [SIDW-1:0]       res_sid;
    logic                  res_ready;
    logic                  all_done;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_eos;
    logic [SIDW-1:0]       out_sid;
    logic [IDW-1:0]        out_wid;
    logic                  finished;

    modport slave (
        input  res_valid, res_vec, res_sid, all_done, out_ready,
        output res_ready, out_valid, out_eos, out_sid, out_wid, finished
    );

    modport master (
        output res_valid, res_vec, res_sid, all_done, out_ready,
        input  res_ready, out_valid, out_eos, out_sid, out_wid, finished
    );

endinterface

// File: rtl/match_result_drain_fifo.sv
// Synchronous record FIFO; occupancy counter is one bit wider than the
// pointers so full and empty are both plain compares.
module drain_fifo #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q;
    logic [AW-1:0]               wr_ptr_q;
    logic [AW-1:0]               rd_ptr_q;
    logic [AW:0]                 count_q;
    logic                        do_push;
    logic                        do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/match_result_drain.sv
// Captures a per-string match vector, emits one record per matched weight
// followed by an end-of-string count record, and flags global completion.
module match_result_drain
    import match_result_drain_pkg::*;
#(
    parameter int unsigned WEIGHT_NUM = WEIGHT_NUM_DEF,
    parameter int unsigned CHUNK      = CHUNK_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    match_result_drain_if.slave bus
);

    localparam int unsigned NCHUNK = (WEIGHT_NUM + CHUNK - 1) / CHUNK;
    localparam int unsigned PADW   = NCHUNK * CHUNK;
    localparam int unsigned CIW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    drain_state_e                 state_q, state_d;
    logic [NCHUNK-1:0][CHUNK-1:0] shadow_q, shadow_d;
    logic [CIW-1:0]               ci_q, ci_d;
    logic [IDW-1:0]               cnt_q, cnt_d;
    logic [SIDW-1:0]              sid_q, sid_d;
    logic                         finished_q, finished_d;

    logic [CHUNK-1:0] window_c;
    logic [LSB_W-1:0] lsb_c;
    logic [IDW-1:0]   base_c;
    drain_rec_t       push_rec_c;
    drain_rec_t       head_rec;
    logic             push_c;
    logic             pop_c;
    logic             fifo_full;
    logic             fifo_empty;

    // The scan base is tracked as a chunk index; base = index * CHUNK.
    assign window_c = shadow_q[ci_q];
    assign lsb_c    = lowest_set_bit(CHUNK_MAX'(window_c));
    assign base_c   = IDW'(ci_q) * IDW'(CHUNK);

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        ci_d       = ci_q;
        cnt_d      = cnt_q;
        sid_d      = sid_q;
        push_c     = 1'b0;
        push_rec_c = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.res_valid) begin
                    shadow_d = PADW'(bus.res_vec);
                    sid_d    = bus.res_sid;
                    ci_d     = '0;
                    cnt_d    = '0;
                    state_d  = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (window_c != '0) begin
                    if (!fifo_full) begin
                        push_c         = 1'b1;
                        push_rec_c.eos = 1'b0;
                        push_rec_c.sid = sid_q;
                        push_rec_c.wid = base_c + IDW'(lsb_c);
                        shadow_d[ci_q] = window_c & (window_c - CHUNK'(1));
                        if (cnt_q != '1) begin
                            cnt_d = cnt_q + IDW'(1);
                        end
                    end
                // Advancing past the last chunk is the "new base >= WEIGHT_NUM" case.
                end else if (ci_q == CIW'(NCHUNK - 1)) begin
                    ci_d    = '0;
                    state_d = ST_EOS;
                end else begin
                    ci_d = ci_q + CIW'(1);
                end
            end
            ST_EOS: begin
                if (!fifo_full) begin
                    push_c         = 1'b1;
                    push_rec_c.eos = 1'b1;
                    push_rec_c.sid = sid_q;
                    push_rec_c.wid = cnt_q;
                    state_d        = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        finished_d = finished_q
                   | (bus.all_done && (state_q == ST_IDLE) && fifo_empty && !bus.res_valid);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shadow_q   <= '0;
            ci_q       <= '0;
            cnt_q      <= '0;
            sid_q      <= '0;
            finished_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            ci_q       <= ci_d;
            cnt_q      <= cnt_d;
            sid_q      <= sid_d;
            finished_q <= finished_d;
        end
    end

    drain_fifo #(
        .WIDTH (REC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .wdata_i (push_rec_c),
        .rdata_o (head_rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign pop_c         = !fifo_empty && bus.out_ready;
    assign bus.res_ready = (state_q == ST_IDLE);
    assign bus.out_valid = !fifo_empty;
    assign bus.out_eos   = head_rec.eos;
    assign bus.out_sid   = head_rec.sid;
    assign bus.out_wid   = head_rec.wid;
    assign bus.finished  = finished_q;

endmodule
